seq_shift_unit: RTL and testbench

//   Parametrised, multi-cycle shift unit for the ALU datapath.

---
 rtl/seq_shift_unit.sv | 150 +++++++++++++++
 tb/tb_seq_shift_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter, up to STEP positions per clock,
// with valid/ready handshakes on the request and result sides.
module seq_shift_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = SHAMT_W + 1;
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;
    logic [1:0]         mode_q, mode_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic [SHAMT_W-1:0] shamt;
    logic [SHAMT_W-1:0] cnt_rem;
    logic [CW-1:0]      k;
    logic [WIDTH-1:0]   fill_mask;
    logic [WIDTH-1:0]   shifted;
    logic               unused_b;

    assign shamt    = B[SHAMT_W-1:0];
    assign unused_b = ^B[WIDTH-1:SHAMT_W];

    // Per-edge shift distance: the remaining count, capped at STEP.
    always_comb begin
        k = STEP_C;
        if ({1'b0, cnt_q} < STEP_C) begin
            k = {1'b0, cnt_q};
        end
    end

    assign cnt_rem   = cnt_q - k[SHAMT_W-1:0];
    assign fill_mask = ~({WIDTH{1'b1}} >> k);

    always_comb begin
        shifted = acc_q;
        unique case (mode_q)
            2'b00: shifted = acc_q << k;
            2'b01: shifted = acc_q >> k;
            2'b10: shifted = (acc_q >> k) | (sign_q ? fill_mask : '0);
            2'b11: shifted = (acc_q >> k) | (acc_q << (WIDTH_C - k));
            default: shifted = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_rem == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d  = acc_q;
        y_d    = y_q;
        sign_d = sign_q;
        ovf_d  = ovf_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (state_q == IDLE && in_valid) begin
            acc_d  = A;
            sign_d = A[WIDTH-1];
            mode_d = op;
            cnt_d  = shamt;
            if (shamt == '0) begin
                y_d   = A;
                ovf_d = 1'b0;
            end
        end else if (state_q == SHIFT) begin
            acc_d = shifted;
            cnt_d = cnt_rem;
            if (cnt_rem == '0) begin
                y_d   = shifted;
                ovf_d = sign_q ^ shifted[WIDTH-1];
            end
        end
    end

    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        busy      = rst_n && (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    assign Y        = y_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: STEP=1 and STEP=4 instances,
// hand-computed results and accept-to-valid latencies.
module tb_seq_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] A, B, Y;
    logic [1:0]  op;
    logic        overflow, busy;
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [15:0] Y4;
    logic        ovf4, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(.WIDTH(16), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .overflow(overflow), .busy(busy)
    );

    seq_shift_unit #(.WIDTH(16), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .A(A), .B(B), .op(op),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .Y(Y4), .overflow(ovf4), .busy(busy4)
    );

    task automatic issue(input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] y,
                         output logic ov, output int lat);
        op = o; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        y = Y; ov = overflow;
    endtask

    task automatic issue4(input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, output logic [15:0] y,
                          output logic ov, output int lat);
        op = o; A = a; B = b; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 1;
        while (!out_valid4 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        y = Y4; ov = ovf4;
    endtask

    task automatic drain;
        out_ready = 1'b1; out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; out_ready4 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold: in_ready=%b busy=%b required 0 0", in_ready, busy);
        end
        checks++;
        if (out_valid !== 1'b0 || Y !== 16'h0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_state: out_valid=%b Y=%h ovf=%b required 0 0000 0",
                     out_valid, Y, overflow);
        end
        rst_n = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: in_ready=%b/%b required 1/1", in_ready, in_ready4);
        end
    endtask

    task automatic test_sra;
        logic [15:0] y; logic ov; int lat;
        issue(2'b10, 16'h8000, 16'd4, y, ov, lat);
        checks++;
        if (y !== 16'hF800 || ov !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL sra: Y=%h ovf=%b lat=%0d required F800 0 5", y, ov, lat);
        end
        drain();
    endtask

    task automatic test_sll_ror;
        logic [15:0] y; logic ov; int lat;
        issue(2'b00, 16'h4001, 16'd1, y, ov, lat);
        checks++;
        if (y !== 16'h8002 || ov !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL sll: Y=%h ovf=%b lat=%0d required 8002 1 2", y, ov, lat);
        end
        drain();
        issue(2'b11, 16'h0001, 16'd1, y, ov, lat);
        checks++;
        if (y !== 16'h8000 || ov !== 1'b1 || lat !== 2) begin
            errors++;
            $display("FAIL ror1: Y=%h ovf=%b lat=%0d required 8000 1 2", y, ov, lat);
        end
        drain();
        issue(2'b11, 16'h1234, 16'd4, y, ov, lat);
        checks++;
        if (y !== 16'h4123 || ov !== 1'b0 || lat !== 5) begin
            errors++;
            $display("FAIL ror4: Y=%h ovf=%b lat=%0d required 4123 0 5", y, ov, lat);
        end
        drain();
        checks++;
        if (Y !== 16'h4123 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL y_retain: Y=%h in_ready=%b busy=%b required 4123 1 0",
                     Y, in_ready, busy);
        end
    endtask

    task automatic test_srl_wide;
        logic [15:0] y; logic ov; int lat;
        issue(2'b01, 16'h8000, 16'h00FF, y, ov, lat);
        checks++;
        if (y !== 16'h0001 || ov !== 1'b1 || lat !== 16) begin
            errors++;
            $display("FAIL srl15: Y=%h ovf=%b lat=%0d required 0001 1 16", y, ov, lat);
        end
        drain();
    endtask

    task automatic test_step4;
        logic [15:0] y; logic ov; int lat;
        issue4(2'b01, 16'h8000, 16'h00FF, y, ov, lat);
        checks++;
        if (y !== 16'h0001 || ov !== 1'b1 || lat !== 5) begin
            errors++;
            $display("FAIL s4_srl15: Y=%h ovf=%b lat=%0d required 0001 1 5", y, ov, lat);
        end
        drain();
        issue4(2'b11, 16'h1234, 16'd5, y, ov, lat);
        checks++;
        if (y !== 16'hA091 || ov !== 1'b1 || lat !== 3) begin
            errors++;
            $display("FAIL s4_ror5: Y=%h ovf=%b lat=%0d required A091 1 3", y, ov, lat);
        end
        drain();
        issue4(2'b10, 16'h8000, 16'd6, y, ov, lat);
        checks++;
        if (y !== 16'hFE00 || ov !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL s4_sra6: Y=%h ovf=%b lat=%0d required FE00 0 3", y, ov, lat);
        end
        drain();
    endtask

    task automatic test_shamt0;
        logic [15:0] y; logic ov; int lat;
        for (int o = 0; o < 4; o++) begin
            issue(2'(o), 16'hA5A5, 16'h0010, y, ov, lat);
            checks++;
            if (y !== 16'hA5A5 || ov !== 1'b0 || lat !== 1) begin
                errors++;
                $display("FAIL shamt0_op%0d: Y=%h ovf=%b lat=%0d required A5A5 0 1",
                         o, y, ov, lat);
            end
            drain();
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] y; logic ov; int lat;
        int bad;
        issue(2'b00, 16'h4001, 16'd1, y, ov, lat);
        op = 2'b00; A = 16'h1234; B = 16'h0000; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (Y !== 16'h8002 || in_ready !== 1'b0 ||
                out_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d bad cycles, last Y=%h in_ready=%b out_valid=%b required 8002 0 1",
                     bad, Y, in_ready, out_valid);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Y !== 16'h8002) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b Y=%h required 0 1 8002",
                     out_valid, in_ready, Y);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || Y !== 16'h1234 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: out_valid=%b Y=%h ovf=%b required 1 1234 0",
                     out_valid, Y, overflow);
        end
        drain();
    endtask

    task automatic test_reset_mid;
        op = 2'b01; A = 16'hFFFF; B = 16'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift: busy=%b out_valid=%b required 1 0", busy, out_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || Y !== 16'h0 || overflow !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: out_valid=%b Y=%h ovf=%b busy=%b in_ready=%b required 0 0000 0 0 0",
                     out_valid, Y, overflow, busy, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_release: in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     in_ready, busy, out_valid);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || Y !== 16'h0) begin
            errors++;
            $display("FAIL mid_rst_discard: out_valid=%b Y=%h required 0 0000", out_valid, Y);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        A = '0; B = '0; op = 2'b00;
        test_reset();
        test_sra();
        test_sll_ror();
        test_srl_wide();
        test_step4();
        test_shamt0();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
